insai_dot_fu: RTL and testbench
===============================

// Module: insai_dot_fu
// PURPOSE
// Pipelined, parametrised custom functional unit for the insAI extension; successor to dummy_FU.
// Sits in ex_stage beside mult/LSU, fed by fu_data_t-derived operands.
// Writes back on its own scoreboard port.
// Computes signed packed-lane dot products, optionally accumulating into NR_ACC internal accumulators.
// PARAMETERS
// XLEN          64  datapath width (32 or 64)
// LANE_W        8   packed lane width (8 or 16); LANES = XLEN/LANE_W
// LATENCY       3   issue-to-writeback cycles, 1..4
// NR_ACC        2   number of internal accumulators (>=1); ACC_W = max(1,$clog2(NR_ACC))
// TRANS_ID_BITS 3   scoreboard transaction id width
// PORTS
// clk_i         in   1              clock
// rst_ni        in   1              asynchronous reset, active low
// flush_i       in   1              kill all in-flight operations
// valid_i       in   1              issue request, accepted when valid_i & ready_o
// ready_o       out  1              unit can accept an issue this cycle
// op_i          in   2              0 DOT, 1 DOTACC, 2 ACCRD, 3 reserved (illegal)
// acc_sel_i     in   ACC_W          accumulator index for DOTACC/ACCRD
// operand_a_i   in   XLEN           rs1 packed lanes
// operand_b_i   in   XLEN           rs2 packed lanes
// trans_id_i    in   TRANS_ID_BITS  scoreboard id of issued op
// valid_o       out  1              writeback valid (single-cycle pulse, no backpressure)
// result_o      out  XLEN           writeback data
// trans_id_o    out  TRANS_ID_BITS  id of written-back op
// ex_valid_o    out  1              writeback carries exception
// ex_cause_o    out  XLEN           exception cause (2 = illegal instruction), tval implied 0
// BEHAVIOUR
// - Reset: all pipeline valids 0, accumulators 0, valid_o=0, result_o=0, trans_id_o=0, ex_valid_o=0, ex_cause_o=0, ready_o=1.
// - Pipeline: LATENCY stages of {valid, op, sel, id, partial}. Op accepted in cycle N writes back in cycle N+LATENCY.
// - Pipeline is fully pipelined for DOT: one DOT accepted per cycle, in order.
// - DOT: sum over LANES of signed(a[i])*signed(b[i]).
//   - Products are 2*LANE_W bits; sum width is 2*LANE_W+$clog2(LANES).
//   - result_o is the sum sign-extended to XLEN.
// - DOTACC: acc[sel] = acc[sel] + sext(dot), modulo 2^XLEN (wraps, no saturation). result_o = new acc value.
// - ACCRD: result_o = acc[sel]; acc[sel] cleared to 0 in the writeback cycle.
// - Accumulator writes happen only in the final stage.
// - Reserved op: no arithmetic, no accumulator change. Writeback after LATENCY cycles with ex_valid_o=1, ex_cause_o=2, result_o=0.
// - Hazard rule: ready_o=0 while any DOTACC/ACCRD is in flight, i.e. from the cycle after accept up to and including its writeback cycle.
//   - Consequence: accumulator ops serialise; each occupies LATENCY cycles.
//   - DOT may be accepted while only DOTs are in flight.
// - Out-of-range acc_sel_i (>= NR_ACC) is treated as reserved op (illegal exception).
// - flush_i:
//   - Clears every pipeline valid in the same cycle; a request presented with flush_i is dropped.
//   - A flushed DOTACC/ACCRD never touches its accumulator.
//   - valid_o is 0 in the cycle after flush.
//   - ready_o=1 the cycle after flush.
//   - Accumulator contents survive flush.
// - Writeback coinciding with flush_i is still emitted; the scoreboard discards it.
// - Reset asserted mid-operation: immediate return to reset values, in-flight ops lost.
// - LATENCY=1: writeback the cycle after accept. ready_o drops for exactly one cycle after an accumulator op.
// TESTING
// - LANE_W=8, a=0x0102030405060708, b=0x0101010101010101, DOT id=5 -> after 3 cycles valid_o=1, result_o=36, trans_id_o=5.
// - a=0xFFFF...FF, b=0x0202...02, DOT -> result_o=0xFFFF_FFFF_FFFF_FFF0 (-16, sign-extended).
// - Back-to-back DOTs ids 1,2,3 on consecutive cycles -> writebacks ids 1,2,3 on consecutive cycles, ready_o stays 1.
// - DOTACC sel0 dot=10, then DOTACC sel0 dot=-3 (second waits for ready_o), then ACCRD sel0.
//   -> results 10, 7, 7; a further ACCRD returns 0.
// - DOTACC sel1 issued, flush_i one cycle later -> no valid_o, ready_o=1 next cycle, ACCRD sel1 returns prior value.
// - op_i=3 id=4 -> valid_o=1, ex_valid_o=1, ex_cause_o=2 after LATENCY. Repeat with acc_sel_i=2, NR_ACC=2 -> same exception.

Source files
------------

// File: rtl/insai_dot_fu_if.sv
// Issue/writeback bundle between the execute stage and the insAI dot-product unit.
// The execute stage takes the master side; the functional unit takes the slave side.
interface insai_dot_fu_if #(
  parameter int XLEN          = 64,
  parameter int NR_ACC        = 2,
  parameter int TRANS_ID_BITS = 3
);
  localparam int ACC_W = (NR_ACC > 1) ? $clog2(NR_ACC) : 1;

  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [1:0]               op_i;
  logic [ACC_W-1:0]         acc_sel_i;
  logic [XLEN-1:0]          operand_a_i;
  logic [XLEN-1:0]          operand_b_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     valid_o;
  logic [XLEN-1:0]          result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  logic                     ex_valid_o;
  logic [XLEN-1:0]          ex_cause_o;

  modport master (
    output flush_i, valid_i, op_i, acc_sel_i, operand_a_i, operand_b_i, trans_id_i,
    input  ready_o, valid_o, result_o, trans_id_o, ex_valid_o, ex_cause_o
  );

  modport slave (
    input  flush_i, valid_i, op_i, acc_sel_i, operand_a_i, operand_b_i, trans_id_i,
    output ready_o, valid_o, result_o, trans_id_o, ex_valid_o, ex_cause_o
  );
endinterface

// File: rtl/insai_dot_fu.sv
// Pipelined signed packed-lane dot-product unit with NR_ACC internal accumulators.
// The dot product is formed at issue; accumulators are read and written only in the last stage.
module insai_dot_fu #(
  parameter int XLEN          = 64,
  parameter int LANE_W        = 8,
  parameter int LATENCY       = 3,
  parameter int NR_ACC        = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  insai_dot_fu_if.slave  fu
);
  localparam int LANES  = XLEN / LANE_W;
  localparam int PROD_W = 2 * LANE_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int ACC_W  = (NR_ACC > 1) ? $clog2(NR_ACC) : 1;
  localparam int LAST   = LATENCY - 1;

  typedef enum logic [1:0] {
    K_DOT = 2'd0,
    K_ACC = 2'd1,
    K_RD  = 2'd2,
    K_ILL = 2'd3
  } kind_e;

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  dot_sum;
  logic [XLEN-1:0]          dot_sext;
  kind_e                    issue_kind;
  logic                     sel_ok;
  logic                     issue;
  logic [LATENCY-1:0]       acc_busy;

  genvar gi;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign prod[gi] = $signed(fu.operand_a_i[gi*LANE_W +: LANE_W])
                      * $signed(fu.operand_b_i[gi*LANE_W +: LANE_W]);
    end
  endgenerate

  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_sum = dot_sum + SUM_W'(prod[i]);
    end
  end

  assign dot_sext = XLEN'(dot_sum);
  assign sel_ok   = (int'(fu.acc_sel_i) < NR_ACC);
  assign issue    = fu.valid_i & fu.ready_o & ~fu.flush_i;

  // Accumulator ops naming a nonexistent accumulator degrade to the illegal op.
  always_comb begin
    issue_kind = K_ILL;
    case (fu.op_i)
      2'd0:    issue_kind = K_DOT;
      2'd1:    issue_kind = sel_ok ? K_ACC : K_ILL;
      2'd2:    issue_kind = sel_ok ? K_RD : K_ILL;
      default: issue_kind = K_ILL;
    endcase
  end

  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic                     vld_reg;
      kind_e                    kind_reg;
      logic [ACC_W-1:0]         sel_reg;
      logic [TRANS_ID_BITS-1:0] id_reg;
      logic [XLEN-1:0]          part_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            vld_reg  <= 1'b0;
            kind_reg <= K_DOT;
            sel_reg  <= '0;
            id_reg   <= '0;
            part_reg <= '0;
          end else begin
            vld_reg <= issue;
            if (issue) begin
              kind_reg <= issue_kind;
              sel_reg  <= fu.acc_sel_i;
              id_reg   <= fu.trans_id_i;
              part_reg <= (issue_kind == K_DOT || issue_kind == K_ACC) ? dot_sext : '0;
            end
          end
        end
      end else begin : g_body
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            vld_reg  <= 1'b0;
            kind_reg <= K_DOT;
            sel_reg  <= '0;
            id_reg   <= '0;
            part_reg <= '0;
          end else begin
            vld_reg <= g_stage[gi-1].vld_reg & ~fu.flush_i;
            if (g_stage[gi-1].vld_reg) begin
              kind_reg <= g_stage[gi-1].kind_reg;
              sel_reg  <= g_stage[gi-1].sel_reg;
              id_reg   <= g_stage[gi-1].id_reg;
              part_reg <= g_stage[gi-1].part_reg;
            end
          end
        end
      end

      assign acc_busy[gi] = vld_reg & (kind_reg == K_ACC || kind_reg == K_RD);
    end
  endgenerate

  // Any accumulator op in flight blocks issue, so accumulator ops never overlap.
  assign fu.ready_o = ~|acc_busy;

  logic                     last_vld;
  kind_e                    last_kind;
  logic [ACC_W-1:0]         last_sel;
  logic [TRANS_ID_BITS-1:0] last_id;
  logic [XLEN-1:0]          last_part;
  logic [NR_ACC*XLEN-1:0]   acc_flat;
  logic [XLEN-1:0]          acc_cur;
  logic [XLEN-1:0]          acc_sum;
  logic                     acc_we;
  logic [XLEN-1:0]          acc_wdata;

  assign last_vld  = g_stage[LAST].vld_reg;
  assign last_kind = g_stage[LAST].kind_reg;
  assign last_sel  = g_stage[LAST].sel_reg;
  assign last_id   = g_stage[LAST].id_reg;
  assign last_part = g_stage[LAST].part_reg;

  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < NR_ACC; i++) begin
      if (last_sel == ACC_W'(i)) begin
        acc_cur = acc_flat[i*XLEN +: XLEN];
      end
    end
  end

  assign acc_sum = acc_cur + last_part;

  // A writeback that coincides with a flush is discarded downstream, so it must not commit.
  assign acc_we    = last_vld & ~fu.flush_i & (last_kind == K_ACC || last_kind == K_RD);
  assign acc_wdata = (last_kind == K_ACC) ? acc_sum : '0;

  generate
    for (gi = 0; gi < NR_ACC; gi++) begin : g_acc
      logic [XLEN-1:0] acc_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          acc_reg <= '0;
        end else if (acc_we && last_sel == ACC_W'(gi)) begin
          acc_reg <= acc_wdata;
        end
      end

      assign acc_flat[gi*XLEN +: XLEN] = acc_reg;
    end
  endgenerate

  always_comb begin
    fu.valid_o    = last_vld;
    fu.trans_id_o = last_vld ? last_id : '0;
    fu.ex_valid_o = last_vld & (last_kind == K_ILL);
    fu.ex_cause_o = (last_vld && last_kind == K_ILL) ? XLEN'(2) : '0;
    fu.result_o   = '0;
    if (last_vld) begin
      case (last_kind)
        K_DOT:   fu.result_o = last_part;
        K_ACC:   fu.result_o = acc_sum;
        K_RD:    fu.result_o = acc_cur;
        default: fu.result_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_insai_dot_fu.sv
// Self-checking bench for insai_dot_fu: directed cases with literal results plus a
// randomized phase checked every cycle against a queue-based behavioural model.
module tb_insai_dot_fu;
  localparam int XLEN   = 64;
  localparam int LANE_W = 8;
  localparam int LAT    = 3;
  localparam int NR_ACC = 2;
  localparam int TID    = 3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  insai_dot_fu_if #(.XLEN(XLEN), .NR_ACC(NR_ACC), .TRANS_ID_BITS(TID)) fu ();
  insai_dot_fu_if #(.XLEN(XLEN), .NR_ACC(3), .TRANS_ID_BITS(TID)) fu3 ();

  insai_dot_fu #(.XLEN(XLEN), .LANE_W(LANE_W), .LATENCY(LAT), .NR_ACC(NR_ACC), .TRANS_ID_BITS(TID))
    u_dut (.clk_i(clk_i), .rst_ni(rst_ni), .fu(fu));

  insai_dot_fu #(.XLEN(XLEN), .LANE_W(LANE_W), .LATENCY(LAT), .NR_ACC(3), .TRANS_ID_BITS(TID))
    u_dut3 (.clk_i(clk_i), .rst_ni(rst_ni), .fu(fu3));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [2:0] id;
    int         kind;   // 0 dot, 1 dotacc, 2 accrd, 3 illegal
    int         sel;
    longint     dot;
  } exp_t;

  exp_t        q[$];
  logic [63:0] macc [NR_ACC];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%h want=0x%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d got=timeout want=event", name, cyc);
  endtask

  function automatic longint dot_of(logic [63:0] a, logic [63:0] b);
    longint s = 0;
    for (int i = 0; i < XLEN / LANE_W; i++) begin
      s += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
    end
    return s;
  endfunction

  // Behavioural model and per-cycle compare.
  initial begin : compare
    exp_t        e;
    logic        exp_ready;
    logic [63:0] r;
    int          k;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("rst_valid_o", fu.valid_o, 0);
        chk("rst_result_o", fu.result_o, 0);
        chk("rst_trans_id_o", fu.trans_id_o, 0);
        chk("rst_ex_valid_o", fu.ex_valid_o, 0);
        chk("rst_ex_cause_o", fu.ex_cause_o, 0);
        chk("rst_ready_o", fu.ready_o, 1);
        q.delete();
        for (int i = 0; i < NR_ACC; i++) macc[i] = '0;
      end else begin
        exp_ready = 1'b1;
        foreach (q[i]) if (q[i].kind == 1 || q[i].kind == 2) exp_ready = 1'b0;
        chk("ready_o", fu.ready_o, exp_ready);
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          r = '0;
          case (e.kind)
            0: r = 64'(e.dot);
            1: begin
              r = macc[e.sel] + 64'(e.dot);
              if (!fu.flush_i) macc[e.sel] = r;
            end
            2: begin
              r = macc[e.sel];
              if (!fu.flush_i) macc[e.sel] = '0;
            end
            default: r = '0;
          endcase
          chk("wb_valid_o", fu.valid_o, 1);
          chk("wb_trans_id_o", fu.trans_id_o, e.id);
          chk("wb_result_o", fu.result_o, r);
          chk("wb_ex_valid_o", fu.ex_valid_o, (e.kind == 3) ? 1 : 0);
          chk("wb_ex_cause_o", fu.ex_cause_o, (e.kind == 3) ? 2 : 0);
        end else begin
          chk("idle_valid_o", fu.valid_o, 0);
          chk("idle_ex_valid_o", fu.ex_valid_o, 0);
        end
        if (fu.flush_i) begin
          q.delete();
        end else if (fu.valid_i && exp_ready) begin
          k = 3;
          if (fu.op_i == 2'd0) k = 0;
          else if (fu.op_i == 2'd1 && int'(fu.acc_sel_i) < NR_ACC) k = 1;
          else if (fu.op_i == 2'd2 && int'(fu.acc_sel_i) < NR_ACC) k = 2;
          e.due  = cyc + LAT;
          e.id   = fu.trans_id_i;
          e.kind = k;
          e.sel  = int'(fu.acc_sel_i);
          e.dot  = dot_of(fu.operand_a_i, fu.operand_b_i);
          q.push_back(e);
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(logic [1:0] op, logic sel, logic [63:0] a, logic [63:0] b, logic [2:0] id);
    bit ok = 0;
    fu.valid_i     = 1'b1;
    fu.op_i        = op;
    fu.acc_sel_i   = sel;
    fu.operand_a_i = a;
    fu.operand_b_i = b;
    fu.trans_id_i  = id;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (fu.ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("issue_wait");
    tick();
    fu.valid_i = 1'b0;
  endtask

  task automatic expect_wb(string name, logic [2:0] id, logic [63:0] res, logic ex, int lat_k);
    bit seen = 0;
    int k;
    for (k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (fu.valid_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      fail_now({name, "_wb"});
    end else begin
      chk({name, "_id"}, fu.trans_id_o, id);
      chk({name, "_result"}, fu.result_o, res);
      chk({name, "_ex"}, fu.ex_valid_o, ex);
      chk({name, "_cause"}, fu.ex_cause_o, ex ? 2 : 0);
      if (lat_k >= 0) chk({name, "_latency"}, 64'(k), 64'(lat_k));
    end
    tick();
  endtask

  task automatic run3(string name, logic [1:0] op, logic [1:0] sel, logic [63:0] a,
                      logic [2:0] id, logic [63:0] res, logic ex);
    chk({name, "_ready"}, fu3.ready_o, 1);
    fu3.valid_i     = 1'b1;
    fu3.op_i        = op;
    fu3.acc_sel_i   = sel;
    fu3.operand_a_i = a;
    fu3.operand_b_i = 64'h1;
    fu3.trans_id_i  = id;
    tick();
    fu3.valid_i = 1'b0;
    repeat (LAT - 1) tick();
    @(negedge clk_i);
    chk({name, "_valid"}, fu3.valid_o, 1);
    chk({name, "_id"}, fu3.trans_id_o, id);
    chk({name, "_result"}, fu3.result_o, res);
    chk({name, "_ex"}, fu3.ex_valid_o, ex);
    chk({name, "_cause"}, fu3.ex_cause_o, ex ? 2 : 0);
    tick();
  endtask

  initial begin : driver
    logic [7:0] idb;
    int         r;
    {fu.flush_i, fu.valid_i, fu.op_i, fu.acc_sel_i, fu.trans_id_i} = '0;
    fu.operand_a_i = '0;
    fu.operand_b_i = '0;
    {fu3.flush_i, fu3.valid_i, fu3.op_i, fu3.acc_sel_i, fu3.trans_id_i} = '0;
    fu3.operand_a_i = '0;
    fu3.operand_b_i = '0;

    chk("model_dot36", 64'(dot_of(64'h0102030405060708, 64'h0101010101010101)), 64'd36);
    chk("model_dotm16", 64'(dot_of(64'hFFFFFFFFFFFFFFFF, 64'h0202020202020202)), 64'hFFFF_FFFF_FFFF_FFF0);

    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    issue(2'd0, 1'b0, 64'h0102030405060708, 64'h0101010101010101, 3'd5);
    expect_wb("dot36", 3'd5, 64'd36, 1'b0, LAT - 1);
    issue(2'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0202020202020202, 3'd0);
    expect_wb("dot_neg16", 3'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, LAT - 1);

    for (int i = 1; i <= 3; i++) begin
      idb = 8'(i);
      issue(2'd0, 1'b0, 64'h0101010101010101, {8{idb}}, 3'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      expect_wb("b2b", 3'(i), 64'(8 * i), 1'b0, 0);
    end

    issue(2'd1, 1'b0, 64'h0A, 64'h01, 3'd1);
    issue(2'd1, 1'b0, 64'hFD, 64'h01, 3'd2);
    expect_wb("dotacc_sum", 3'd2, 64'd7, 1'b0, LAT - 1);
    issue(2'd2, 1'b0, 64'h0, 64'h0, 3'd3);
    expect_wb("accrd_7", 3'd3, 64'd7, 1'b0, LAT - 1);
    issue(2'd2, 1'b0, 64'h0, 64'h0, 3'd4);
    expect_wb("accrd_cleared", 3'd4, 64'd0, 1'b0, LAT - 1);

    issue(2'd1, 1'b1, 64'h05, 64'h01, 3'd1);
    expect_wb("acc1_seed", 3'd1, 64'd5, 1'b0, LAT - 1);
    issue(2'd1, 1'b1, 64'h64, 64'h01, 3'd2);
    fu.flush_i = 1'b1;
    tick();
    fu.flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_ready_next", fu.ready_o, 1);
    chk("flush_valid_next", fu.valid_o, 0);
    tick();
    issue(2'd2, 1'b1, 64'h0, 64'h0, 3'd3);
    expect_wb("flush_acc_kept", 3'd3, 64'd5, 1'b0, LAT - 1);

    issue(2'd3, 1'b0, 64'h1234, 64'h1, 3'd4);
    expect_wb("illegal_op", 3'd4, 64'd0, 1'b1, LAT - 1);

    issue(2'd1, 1'b1, 64'h05, 64'h01, 3'd5);
    expect_wb("pre_reset_acc", 3'd5, 64'd5, 1'b0, LAT - 1);
    issue(2'd0, 1'b0, 64'h0102030405060708, 64'h0101010101010101, 3'd6);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (LAT + 1) tick();
    issue(2'd2, 1'b1, 64'h0, 64'h0, 3'd7);
    expect_wb("post_reset_acc", 3'd7, 64'd0, 1'b0, LAT - 1);

    run3("sel3_illegal", 2'd2, 2'd3, 64'h0, 3'd6, 64'd0, 1'b1);
    run3("sel2_dotacc", 2'd1, 2'd2, 64'h09, 3'd7, 64'd9, 1'b0);
    run3("sel2_accrd", 2'd2, 2'd2, 64'h0, 3'd1, 64'd9, 1'b0);

    for (int c = 0; c < 600; c++) begin
      fu.valid_i = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      fu.op_i = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      fu.acc_sel_i   = 1'($urandom_range(0, 1));
      fu.trans_id_i  = 3'($urandom_range(0, 7));
      fu.operand_a_i = {$urandom, $urandom};
      fu.operand_b_i = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) begin
        fu.operand_a_i = 64'h8080808080808080;
        fu.operand_b_i = 64'h8080808080808080;
      end
      fu.flush_i = fu.ready_o && ($urandom_range(0, 19) == 0);
      tick();
    end
    fu.valid_i = 1'b0;
    fu.flush_i = 1'b0;
    repeat (LAT + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
